// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: walks one digit per refresh slot, drives BCD code,
// active-low anodes and decimal point, with frame-synchronous double-buffered digit updates.
module display_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DIV_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic        dp,
    output logic [1:0]  digit_idx,
    output logic        frame_start
);

    localparam logic [DIV_W-1:0] TC = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      act_q, act_d;
    logic [3:0]       act_dp_q, act_dp_d;
    logic [15:0]      shd_q, shd_d;
    logic [3:0]       shd_dp_q, shd_dp_d;
    logic             pend_q, pend_d;
    logic [3:0]       bcd_q, bcd_d;
    logic [3:0]       an_q, an_d;
    logic             dp_q, dp_d;
    logic             fs_q, fs_d;

    logic       tick;
    logic       wrap;
    logic       zero3, zero2, zero1;
    logic [3:0] blank;

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        act_d    = act_q;
        act_dp_d = act_dp_q;
        shd_d    = shd_q;
        shd_dp_d = shd_dp_q;
        pend_d   = pend_q;

        tick = enable && (cnt_q == TC);
        wrap = tick && (idx_q == 2'd3);

        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        if (tick) begin
            idx_d = idx_q + 2'd1;
        end

        // A load landing on the wrap tick bypasses the shadow and wins over any pending value.
        if (load) begin
            if (wrap) begin
                act_d    = digits_in;
                act_dp_d = dp_in;
                pend_d   = 1'b0;
            end else begin
                shd_d    = digits_in;
                shd_dp_d = dp_in;
                pend_d   = 1'b1;
            end
        end else if (wrap && pend_q) begin
            act_d    = shd_q;
            act_dp_d = shd_dp_q;
            pend_d   = 1'b0;
        end

        zero3 = (act_d[15:12] == 4'd0);
        zero2 = zero3 && (act_d[11:8] == 4'd0);
        zero1 = zero2 && (act_d[7:4] == 4'd0);

        blank[0] = 1'b0;
        blank[1] = blank_lz && zero1 && !act_dp_d[1];
        blank[2] = blank_lz && zero2 && !act_dp_d[2];
        blank[3] = blank_lz && zero3 && !act_dp_d[3];

        // Outputs are computed from next-state index/digits so they change on the tick edge itself.
        bcd_d = act_d[{idx_d, 2'b00} +: 4];
        an_d  = (enable && !blank[idx_d]) ? ~(4'b0001 << idx_d) : 4'b1111;
        dp_d  = enable ? ~act_dp_d[idx_d] : 1'b1;
        fs_d  = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            act_q    <= 16'd0;
            act_dp_q <= 4'd0;
            shd_q    <= 16'd0;
            shd_dp_q <= 4'd0;
            pend_q   <= 1'b0;
            bcd_q    <= 4'd0;
            an_q     <= 4'b1111;
            dp_q     <= 1'b1;
            fs_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            act_q    <= act_d;
            act_dp_q <= act_dp_d;
            shd_q    <= shd_d;
            shd_dp_q <= shd_dp_d;
            pend_q   <= pend_d;
            bcd_q    <= bcd_d;
            an_q     <= an_d;
            dp_q     <= dp_d;
            fs_q     <= fs_d;
        end
    end

    assign bcd         = bcd_q;
    assign an          = an_q;
    assign dp          = dp_q;
    assign digit_idx   = idx_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with REFRESH_DIV = 4; expected slot contents are queued
// before each slot and popped when the DUT presents that slot.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = 16'd0;
    logic [3:0]  dp_in = 4'd0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_start;

    display_scan_ctrl #(.REFRESH_DIV(4), .DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .bcd(bcd), .an(an), .dp(dp), .digit_idx(digit_idx), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [1:0] idx;
        logic [3:0] bcd;
        logic [3:0] an;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input string tag, input logic [1:0] i, input logic [3:0] b,
                        input logic [3:0] a, input logic d);
        exp_t e;
        e.tag = tag; e.idx = i; e.bcd = b; e.an = a; e.dp = d;
        sb.push_back(e);
    endtask

    task automatic check_slot();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL scoreboard_underflow observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_idx"}, {6'd0, digit_idx}, {6'd0, e.idx});
            chk({e.tag, "_bcd"}, {4'd0, bcd}, {4'd0, e.bcd});
            chk({e.tag, "_an"},  {4'd0, an},  {4'd0, e.an});
            chk({e.tag, "_dp"},  {7'd0, dp},  {7'd0, e.dp});
        end
    endtask

    task automatic load_pulse(input logic [15:0] d, input logic [3:0] p);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        step(1);
        load      = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!frame_start && n < 40);
        chk({tag, "_frame_seen"}, {7'd0, frame_start}, 8'd1);
    endtask

    // Walks four 4-cycle slots from slot 0 cycle 0, checking each slot's queued entry.
    task automatic run_frame(input string tag);
        int fs_cnt;
        fs_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            check_slot();
            for (int c = 0; c < 4; c++) begin
                step(1);
                if (frame_start) fs_cnt++;
            end
        end
        chk({tag, "_fs_per_frame"}, 8'(fs_cnt), 8'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset state and first tick
        step(3);
        push("rst", 2'd0, 4'd0, 4'b1111, 1'b1);
        check_slot();
        chk("rst_fs", {7'd0, frame_start}, 8'd0);
        rst_n = 1'b1;
        step(3);
        chk("pre_tick_idx", {6'd0, digit_idx}, 8'd0);
        step(1);
        push("tick1", 2'd1, 4'd0, 4'b1101, 1'b1);
        check_slot();

        // 2: basic scan of 1234 with dp on digit 2
        load_pulse(16'h1234, 4'b0100);
        wait_frame("t2");
        push("t2_s0", 2'd0, 4'd4, 4'b1110, 1'b1);
        push("t2_s1", 2'd1, 4'd3, 4'b1101, 1'b1);
        push("t2_s2", 2'd2, 4'd2, 4'b1011, 1'b0);
        push("t2_s3", 2'd3, 4'd1, 4'b0111, 1'b1);
        run_frame("t2");

        // 3: leading-zero blanking, then a lit dp on digit 3 defeats blanking of that digit
        blank_lz = 1'b1;
        load_pulse(16'h0042, 4'b0000);
        wait_frame("t3a");
        push("t3a_s0", 2'd0, 4'd2, 4'b1110, 1'b1);
        push("t3a_s1", 2'd1, 4'd4, 4'b1101, 1'b1);
        push("t3a_s2", 2'd2, 4'd0, 4'b1111, 1'b1);
        push("t3a_s3", 2'd3, 4'd0, 4'b1111, 1'b1);
        run_frame("t3a");
        load_pulse(16'h0042, 4'b1000);
        wait_frame("t3b");
        push("t3b_s0", 2'd0, 4'd2, 4'b1110, 1'b1);
        push("t3b_s1", 2'd1, 4'd4, 4'b1101, 1'b1);
        push("t3b_s2", 2'd2, 4'd0, 4'b1111, 1'b1);
        push("t3b_s3", 2'd3, 4'd0, 4'b0111, 1'b0);
        run_frame("t3b");

        // 4: double buffering
        blank_lz = 1'b0;
        load_pulse(16'h1111, 4'b0000);
        wait_frame("t4");
        push("t4_s0", 2'd0, 4'd1, 4'b1110, 1'b1);
        check_slot();
        step(4);
        load_pulse(16'h9999, 4'b0000);
        push("t4_s1", 2'd1, 4'd1, 4'b1101, 1'b1);
        check_slot();
        step(3);
        push("t4_s2", 2'd2, 4'd1, 4'b1011, 1'b1);
        check_slot();
        step(4);
        push("t4_s3", 2'd3, 4'd1, 4'b0111, 1'b1);
        check_slot();
        step(4);
        push("t4_nine", 2'd0, 4'd9, 4'b1110, 1'b1);
        check_slot();
        chk("t4_nine_fs", {7'd0, frame_start}, 8'd1);
        step(4);
        load_pulse(16'h7777, 4'b0000);
        step(10);
        load_pulse(16'h5555, 4'b0000);
        push("t4_wrapload", 2'd0, 4'd5, 4'b1110, 1'b1);
        check_slot();
        step(4);
        push("t4_five_s1", 2'd1, 4'd5, 4'b1101, 1'b1);
        check_slot();
        load_pulse(16'h2222, 4'b0000);
        load_pulse(16'h3333, 4'b0000);
        step(10);
        push("t4_lastwins", 2'd0, 4'd3, 4'b1110, 1'b1);
        check_slot();

        // 5: enable dropped mid-slot 2 (one cycle into the slot)
        step(9);
        enable = 1'b0;
        step(1);
        push("t5_off", 2'd2, 4'd3, 4'b1111, 1'b1);
        check_slot();
        chk("t5_off_fs", {7'd0, frame_start}, 8'd0);
        step(9);
        push("t5_held", 2'd2, 4'd3, 4'b1111, 1'b1);
        check_slot();
        enable = 1'b1;
        step(2);
        push("t5_resume", 2'd2, 4'd3, 4'b1011, 1'b1);
        check_slot();
        step(1);
        push("t5_next", 2'd3, 4'd3, 4'b0111, 1'b1);
        check_slot();

        // 6: asynchronous reset mid-slot 3 with a load pending
        load_pulse(16'h8888, 4'b0000);
        step(1);
        rst_n = 1'b0;
        #1;
        push("t6_rst", 2'd0, 4'd0, 4'b1111, 1'b1);
        check_slot();
        chk("t6_rst_fs", {7'd0, frame_start}, 8'd0);
        #2;
        rst_n    = 1'b1;
        blank_lz = 1'b1;
        wait_frame("t6");
        push("t6_s0", 2'd0, 4'd0, 4'b1110, 1'b1);
        push("t6_s1", 2'd1, 4'd0, 4'b1111, 1'b1);
        push("t6_s2", 2'd2, 4'd0, 4'b1111, 1'b1);
        push("t6_s3", 2'd3, 4'd0, 4'b1111, 1'b1);
        run_frame("t6");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit seven-segment display in the wishbone display unit. It holds four BCD digits and four decimal points. It selects one digit per refresh slot and drives that digit's code into the downstream BCD-to-segment decoder, along with the active-low digit anode enables. Digit updates are double-buffered and applied only at frame boundaries, so a scan never shows a mix of old and new digits.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot (50 MHz gives 1 kHz per slot and 250 Hz per frame); legal range 2..65535.
DIV_W, 16, prescaler width; must satisfy 2^DIV_W >= REFRESH_DIV.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = scanning; 0 = display dark, scan frozen
load  input  1  single-cycle strobe: capture digits_in/dp_in into shadow
digits_in  input  16  four BCD digits; [3:0] = digit 0 (rightmost) … [15:12] = digit 3
dp_in  input  4  decimal point request per digit, bit k = digit k, 1 = lit
blank_lz  input  1  1 = suppress leading zeros
bcd  output  4  code of currently selected digit, to decoder input
an  output  4  anode enables, active-low, an[k] = digit k
dp  output  1  decimal point segment, active-low
digit_idx  output  2  index of currently selected digit
frame_start  output  1  one-cycle pulse when digit_idx wraps 3→0

Behaviour:
- All outputs are registered. Reset is asynchronous and active-low: clk and rst_n, reset asserts on rst_n low.
- Reset values:
  - active and shadow digits = 0; active and shadow dp = 0; pending = 0; prescaler = 0.
  - digit_idx = 0, bcd = 0, an = 4'b1111, dp = 1, frame_start = 0.
- Prescaler: counts 0..REFRESH_DIV-1 while enable = 1. tick = (count == REFRESH_DIV-1); on tick, count wraps to 0.
- On tick: digit_idx <= digit_idx + 1 (mod 4). bcd, an and dp update on the same edge from the new index. No extra latency.
- Output mapping for the selected index k:
  - bcd = active digit k.
  - an = ~(1<<k), unless digit k is blanked, then 4'b1111.
  - dp = ~active_dp[k].
- frame_start = 1 for exactly the cycle following the edge where digit_idx went 3→0.
- Double buffering:
  - load = 1 writes digits_in/dp_in to the shadow registers and sets pending.
  - On a tick with digit_idx = 3 and pending = 1: active <= shadow, pending <= 0. The new values are visible starting at slot 0 on that same edge.
  - If load coincides with that wrap tick, digits_in/dp_in go directly to active and pending clears. The new load wins; the old shadow is discarded.
  - Repeated loads within one frame: the last one wins.
- Leading-zero blanking (blank_lz = 1): digit k in 1..3 is blanked when active digits k..3 are all 0 and active_dp[k] = 0. Digit 0 is never blanked. A blanked slot still occupies its time slot and bcd is still driven.
- Codes 10..15 pass through unmodified; the decoder handles them. They count as nonzero for blanking.
- enable = 0:
  - prescaler and digit_idx hold; an forced to 4'b1111 on the next edge; dp = 1; frame_start = 0.
  - load and the pending transfer still operate as specified, except no transfer occurs because there are no ticks.
  - When enable returns to 1, scanning resumes from the held count and index.
- rst_n asserted mid-frame: everything returns to reset values immediately, asynchronously; pending loads are lost.

Test Plan:
1. REFRESH_DIV = 4. Hold rst_n = 0, then release with enable = 1. Required: an = 1111, dp = 1, bcd = 0 while in reset. First tick at cycle 4: digit_idx = 1, an = 1101, bcd = 0.
2. Load 16'h1234 with dp_in = 4'b0100, blank_lz = 0, REFRESH_DIV = 4. After the next frame wrap, each slot lasts 4 cycles:
   - slot 0: bcd = 4, an = 1110, dp = 1
   - slot 1: bcd = 3, an = 1101
   - slot 2: bcd = 2, an = 1011, dp = 0
   - slot 3: bcd = 1, an = 0111
   - frame_start pulses once per 16 cycles.
3. Load 16'h0042 with blank_lz = 1. Required: slots 2 and 3 give an = 1111; slots 0 and 1 give bcd = 2 and 4. Repeat with dp_in = 4'b1000: slot 3 is then lit with bcd = 0, dp = 0.
4. Active value 16'h1111. Load 16'h9999 during slot 1. Required: slots 1–3 still show 1; 9 first appears at slot 0 of the next frame. Then load 16'h5555 exactly on the 3→0 tick: slot 0 shows 5 immediately.
5. Drop enable for 10 cycles mid-slot 2. Required: an = 1111 from the next edge; digit_idx stays 2; the prescaler count is held. After enable is restored, the remaining cycles of slot 2 complete before digit_idx = 3.
6. Pulse rst_n low for 3 ns, asynchronously, mid-slot 3 with a load pending. Required: outputs go to reset values without a clock edge. After release, the display shows 0000 (digit 0 only when blank_lz = 1).
